// File: rtl/sprow_pkg.sv
// Shared types for the sparse-row feeder: matrix geometry, FSM states and the row beat struct.
// The top checks at elaboration that its parameters match the geometry defined here.
package sprow_pkg;

  localparam int unsigned MatRank = 256;
  localparam int unsigned Dw      = 32;
  localparam int unsigned Iw      = $clog2(MatRank);
  // One RAM word: {col_idx3..col_idx0, val}; val slot k = {imag_k, real_k}
  localparam int unsigned WordW   = 4 * Iw + 8 * Dw;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    logic [3:0][Iw-1:0] col_idx;
    logic [3:0][Dw-1:0] val_i;
    logic [3:0][Dw-1:0] val_r;
    logic [Iw-1:0]      row;
    logic               last;
  } sprow_t;

  // Split a stored RAM word into a beat, tagging it with its row number
  function automatic sprow_t unpack_word(input logic [WordW-1:0] w, input logic [Iw-1:0] row,
                                         input logic last);
    sprow_t b;
    for (int k = 0; k < 4; k++) begin
      b.col_idx[k] = w[8*Dw + Iw*k +: Iw];
      b.val_r[k]   = w[2*Dw*k +: Dw];
      b.val_i[k]   = w[2*Dw*k + Dw +: Dw];
    end
    b.row  = row;
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/sprow_skid_fifo.sv
// Two-entry FIFO of row beats. The head entry is the registered output; the second entry
// absorbs a beat that arrives while the head is stalled. Pushing when full is only legal
// together with a pop.
module sprow_skid_fifo
  import sprow_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  sprow_t     data_i,
  input  logic       rdy_i,
  output sprow_t     head_o,
  output logic       vld_o,
  output logic [1:0] count_o
);

  sprow_t     head_q, head_d;
  sprow_t     skid_q, skid_d;
  logic [1:0] cnt_q, cnt_d;
  logic       vld_q;
  logic       pop;

  // Next-state for head/skid entries and occupancy
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    pop    = vld_q && rdy_i;
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          head_d = data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop) begin
          head_d = data_i;
        end else if (push_i) begin
          skid_d = data_i;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = skid_q;
          if (push_i) begin
            skid_d = data_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Storage and registered valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      vld_q  <= (cnt_d != 2'd0);
    end
  end

  assign head_o  = head_q;
  assign vld_o   = vld_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/sprow_feeder.sv
// Sparse precoding-matrix row feeder. Holds MAT_RANK rows of 4 (col_idx, complex value) pairs
// in a synchronous RAM written through the cfg port while idle, and on start streams every row
// in order over a valid/ready channel.
// Optional build macro SPROW_STATS_EN adds the stat_rows_o / stat_stall_o run counters.
module sprow_feeder
  import sprow_pkg::*;
#(
  parameter  int unsigned MAT_RANK = MatRank,
  parameter  int unsigned DW       = Dw,
  localparam int unsigned IW       = $clog2(MAT_RANK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr_en_i,
  input  logic [IW-1:0]        cfg_wr_addr_i,
  input  logic [4*IW+8*DW-1:0] cfg_wr_data_i,
  output logic                 cfg_err_o,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*IW-1:0]      s_col_index_o,
  output logic [8*DW-1:0]      s_val_o,
  output logic [IW-1:0]        s_row_o,
  output logic                 s_last_o,
  output logic                 s_vld_o,
`ifdef SPROW_STATS_EN
  output logic [IW:0]          stat_rows_o,
  output logic [31:0]          stat_stall_o,
`endif
  input  logic                 s_rdy_i
);

  if (MAT_RANK != MatRank || DW != Dw) begin : g_geom_check
    $error("sprow_feeder geometry must match sprow_pkg");
  end

  localparam logic [IW-1:0] LastRow = IW'(MAT_RANK - 1);

  logic [4*IW+8*DW-1:0] mem_q [MAT_RANK];
  logic [4*IW+8*DW-1:0] rdata_q;

  state_e        state_q;
  logic [IW-1:0] raddr_q;
  logic          busy_q, done_q, cfg_err_q;
  logic          pend_q;
  logic [IW-1:0] pend_row_q;

  logic          wr_ok, start_ok, issue, push, skid_full, hs;
  logic [1:0]    fifo_cnt;
  sprow_t        push_row, head;

  // Read credit: the head register is the output stage, so issue is blocked only when both the
  // skid entry and the RAM output register are occupied. No s_rdy term reaches the RAM.
  always_comb begin
    skid_full = (fifo_cnt == 2'd2);
    hs        = s_vld_o && s_rdy_i;
    wr_ok     = cfg_wr_en_i && (state_q == StIdle);
    start_ok  = start_i && (state_q == StIdle);
    issue     = (state_q == StRun) && !(skid_full && pend_q);
    push      = pend_q && (!skid_full || hs);
    push_row  = unpack_word(rdata_q, pend_row_q, pend_row_q == LastRow);
  end

  // Matrix RAM, not reset. Reads occur only in RUN and writes only in IDLE, so a write followed
  // by start always lands before row 0 is read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[cfg_wr_addr_i] <= cfg_wr_data_i;
    end
    if (issue) begin
      rdata_q <= mem_q[raddr_q];
    end
  end

  // Track the RAM output register: holds one read until it moves into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_row_q <= '0;
    end else if (issue) begin
      pend_q     <= 1'b1;
      pend_row_q <= raddr_q;
    end else if (push) begin
      pend_q <= 1'b0;
    end
  end

  // Control FSM with read-address counter and registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      raddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= cfg_wr_en_i && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            raddr_q <= '0;
          end
        end
        StRun: begin
          if (issue) begin
            raddr_q <= raddr_q + 1'b1;
            if (raddr_q == LastRow) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (hs && s_last_o) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sprow_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_row),
    .rdy_i   (s_rdy_i),
    .head_o  (head),
    .vld_o   (s_vld_o),
    .count_o (fifo_cnt)
  );

  // Flatten the head beat onto the output buses
  always_comb begin
    s_col_index_o = '0;
    s_val_o       = '0;
    for (int k = 0; k < 4; k++) begin
      s_col_index_o[IW*k +: IW] = head.col_idx[k];
      s_val_o[2*DW*k +: 2*DW]   = {head.val_i[k], head.val_r[k]};
    end
    s_row_o  = head.row;
    // Head keeps its last flag after the final pop; gate it so s_last never shows while idle
    s_last_o = s_vld_o && head.last;
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;

`ifdef SPROW_STATS_EN
  logic [IW:0]  stat_rows_q;
  logic [31:0]  stat_stall_q;

  // Per-run beat and stall counters, cleared on accepted start, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rows_q  <= '0;
      stat_stall_q <= '0;
    end else if (start_ok) begin
      stat_rows_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (hs && !(&stat_rows_q)) begin
        stat_rows_q <= stat_rows_q + 1'b1;
      end
      if (s_vld_o && !s_rdy_i && !(&stat_stall_q)) begin
        stat_stall_q <= stat_stall_q + 1'b1;
      end
    end
  end

  assign stat_rows_o  = stat_rows_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_sprow_feeder.sv
// Directed bench for sprow_feeder: streaming latency/order, backpressure, busy-time cfg writes,
// start re-pulse, mid-run reset, and (with SPROW_STATS_EN) the run counters.
module tb_sprow_feeder;

  localparam int unsigned N  = 256;
  localparam int unsigned IW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 4 * IW + 8 * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_wr_en = 1'b0;
  logic [IW-1:0]   cfg_wr_addr = '0;
  logic [WW-1:0]   cfg_wr_data = '0;
  logic            cfg_err;
  logic            start = 1'b0;
  logic            busy, done;
  logic [4*IW-1:0] s_col_index;
  logic [8*DW-1:0] s_val;
  logic [IW-1:0]   s_row;
  logic            s_last, s_vld;
  logic            s_rdy = 1'b0;
`ifdef SPROW_STATS_EN
  logic [IW:0]     stat_rows;
  logic [31:0]     stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprow_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr_en_i   (cfg_wr_en),
    .cfg_wr_addr_i (cfg_wr_addr),
    .cfg_wr_data_i (cfg_wr_data),
    .cfg_err_o     (cfg_err),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .s_col_index_o (s_col_index),
    .s_val_o       (s_val),
    .s_row_o       (s_row),
    .s_last_o      (s_last),
    .s_vld_o       (s_vld),
`ifdef SPROW_STATS_EN
    .stat_rows_o   (stat_rows),
    .stat_stall_o  (stat_stall),
`endif
    .s_rdy_i       (s_rdy)
  );

  // Row r: col_idx k = (r+k)%256, value slot k = {imag=k+1, real=r+alt}
  function automatic logic [WW-1:0] row_word(input int r, input int alt);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w[8*DW + IW*k +: IW] = IW'((r + k) % N);
      w[2*DW*k +: DW]      = DW'(r + alt);
      w[2*DW*k + DW +: DW] = DW'(k + 1);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_vld, busy, done, cfg_err, s_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got vld/busy/done/err/last=%b want 00000",
               {s_vld, busy, done, cfg_err, s_last});
    end
    checks++;
    if (s_row !== '0) begin
      errors++;
      $display("FAIL reset_s_row got %0d want 0", s_row);
    end
    checks++;
    if (s_col_index !== '0) begin
      errors++;
      $display("FAIL reset_s_col_index got %h want 0", s_col_index);
    end
    checks++;
    if (s_val !== '0) begin
      errors++;
      $display("FAIL reset_s_val got %h want 0", s_val);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_matrix();
    int err_seen;
    err_seen = 0;
    for (int r = 0; r < int'(N); r++) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = IW'(r);
      cfg_wr_data = row_word(r, 0);
      tick();
      if (cfg_err) err_seen++;
    end
    cfg_wr_en = 1'b0;
    tick();
    if (cfg_err) err_seen++;
    checks++;
    if (err_seen != 0) begin
      errors++;
      $display("FAIL idle_cfg_err got %0d pulses want 0", err_seen);
    end
  endtask

  task automatic test_stream();
    logic exp_vld, exp_busy, exp_done;
    s_rdy = 1'b1;
    pulse_start();
    for (int c = 0; c <= 260; c++) begin
      @(negedge clk);
      exp_vld  = (c >= 2) && (c <= 257);
      exp_busy = (c <= 257);
      exp_done = (c == 258);
      checks++;
      if ({s_vld, busy, done} !== {exp_vld, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL stream_ctrl cyc %0d got vld/busy/done=%b want %b", c,
                 {s_vld, busy, done}, {exp_vld, exp_busy, exp_done});
      end
      if (exp_vld) begin
        checks++;
        if (s_row !== IW'(c - 2) || s_last !== (c == 257) ||
            {s_col_index, s_val} !== row_word(c - 2, 0)) begin
          errors++;
          $display("FAIL stream_beat cyc %0d got row %0d last %b data %h want row %0d last %b data %h",
                   c, s_row, s_last, {s_col_index, s_val}, c - 2, (c == 257), row_word(c - 2, 0));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_row, dones, cyc;
    logic p_vld, p_rdy;
    logic [IW+WW-1:0] p_bundle, cur;
    exp_row = 0; dones = 0; cyc = 0;
    p_vld = 1'b0; p_rdy = 1'b0; p_bundle = '0;
    s_rdy = 1'b0;
    pulse_start();
    while (dones == 0 && cyc < 3000) begin
      @(negedge clk);
      cur = {s_row, s_col_index, s_val};
      if (p_vld && !p_rdy) begin
        checks++;
        if (!s_vld || cur !== p_bundle) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got vld %b %h want vld 1 %h", cyc, s_vld, cur, p_bundle);
        end
      end
      if (s_vld && s_rdy) begin
        checks++;
        if (s_row !== IW'(exp_row) || {s_col_index, s_val} !== row_word(exp_row, 0)) begin
          errors++;
          $display("FAIL bp_beat got row %0d data %h want row %0d data %h", s_row,
                   {s_col_index, s_val}, exp_row, row_word(exp_row, 0));
        end
        exp_row++;
      end
      if (done) dones++;
      p_vld = s_vld; p_rdy = s_rdy; p_bundle = cur;
      @(posedge clk);
      #1;
      s_rdy = 1'($urandom_range(0, 1));
      cyc++;
    end
    s_rdy = 1'b1;
    checks++;
    if (exp_row != 256 || dones != 1) begin
      errors++;
      $display("FAIL bp_count got beats %0d dones %0d want 256 and 1", exp_row, dones);
    end
  endtask

  task automatic test_cfg_busy();
    int seen5, dones;
    s_rdy = 1'b1;
    pulse_start();
    repeat (3) tick();
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = IW'(5);
    cfg_wr_data = row_word(5, 77);
    tick();
    cfg_wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_pulse got %b want 1", cfg_err);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_width got %b want 0", cfg_err);
    end
    dones = 0;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL cfg_run_done got %0d want 1", dones);
    end
    tick();
    pulse_start();
    seen5 = 0;
    for (int c = 0; c <= 260; c++) begin
      @(negedge clk);
      if (s_vld && s_row == IW'(5)) begin
        seen5++;
        checks++;
        if ({s_col_index, s_val} !== row_word(5, 0)) begin
          errors++;
          $display("FAIL row5_kept got %h want %h", {s_col_index, s_val}, row_word(5, 0));
        end
      end
    end
    checks++;
    if (seen5 != 1) begin
      errors++;
      $display("FAIL row5_seen got %0d want 1", seen5);
    end
  endtask

  task automatic test_restart();
    int beats, dones;
    logic pulsed, ordered;
    beats = 0; dones = 0; pulsed = 1'b0; ordered = 1'b1;
    s_rdy = 1'b1;
    tick();
    pulse_start();
    for (int c = 0; c <= 300; c++) begin
      @(negedge clk);
      if (s_vld && s_rdy) begin
        if (s_row !== IW'(beats)) ordered = 1'b0;
        beats++;
      end
      if (done) dones++;
      @(posedge clk);
      #1;
      start = (beats == 100) && !pulsed;
      if (start) pulsed = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (beats != 256 || dones != 1 || !ordered) begin
      errors++;
      $display("FAIL restart_ignored got beats %0d dones %0d ordered %b want 256 1 1",
               beats, dones, ordered);
    end
  endtask

  task automatic test_reset_midrun();
    int beats, cyc, dseen, dones;
    beats = 0; cyc = 0; dseen = 0; dones = 0;
    s_rdy = 1'b1;
    tick();
    pulse_start();
    while (beats < 50 && cyc < 400) begin
      @(negedge clk);
      if (s_vld && s_rdy) beats++;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_vld, busy, done} !== 3'b000 || beats != 50) begin
      errors++;
      $display("FAIL abort_state got vld/busy/done=%b beats %0d want 000 50", {s_vld, busy, done},
               beats);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dseen++;
    end
    checks++;
    if (dseen != 0 || s_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got dones %0d vld %b busy %b want 0 0 0", dseen, s_vld, busy);
    end
    tick();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_vld !== 1'b0) begin
      errors++;
      $display("FAIL replay_early got vld %b want 0", s_vld);
    end
    @(negedge clk);
    checks++;
    if (s_vld !== 1'b1 || s_row !== '0 || {s_col_index, s_val} !== row_word(0, 0)) begin
      errors++;
      $display("FAIL replay_row0 got vld %b row %0d data %h want 1 0 %h", s_vld, s_row,
               {s_col_index, s_val}, row_word(0, 0));
    end
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL replay_done got %0d want 1", dones);
    end
  endtask

`ifdef SPROW_STATS_EN
  task automatic test_stats();
    int dones;
    dones = 0;
    s_rdy = 1'b0;
    tick();
    pulse_start();
    repeat (12) @(posedge clk);
    #1;
    s_rdy = 1'b1;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        checks++;
        if (stat_stall !== 32'd10 || stat_rows !== 9'd256) begin
          errors++;
          $display("FAIL stats got stall %0d rows %0d want 10 256", stat_stall, stat_rows);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL stats_done got %0d want 1", dones);
    end
  endtask
`endif

  initial begin
    test_reset();
    load_matrix();
    test_stream();
    test_backpressure();
    test_cfg_busy();
    test_restart();
    test_reset_midrun();
`ifdef SPROW_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
